// File: rtl/key_uart_framer.sv
// Key-event framer: queues decoded key events and sends each one to a UART as a header byte plus an ASCII byte.
// Optional macro KEY_RELEASE_EN: also queue release events and frame them with RELEASE_HDR.
module key_uart_framer #(
    parameter int         DEPTH       = 16,
    parameter logic [7:0] PRESS_HDR   = 8'h01,
    parameter logic [7:0] RELEASE_HDR = 8'h02
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_valid,
    input  logic                     key_press,
    input  logic [7:0]               key_ascii,
    input  logic                     tx_done,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef KEY_RELEASE_EN
    localparam int EW = 9;
`else
    localparam int EW = 8;
`endif
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [2:0] {IDLE, SEND_HDR, WAIT_HDR, SEND_DAT, WAIT_DAT} state_t;

    state_t          state_r;
    logic [EW-1:0]   mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [LW-1:0]   level_r;
    logic [LW-1:0]   level_next_s;
    logic            full_r;
    logic            empty_r;
    logic            overflow_r;
    logic            tx_start_r;
    logic [7:0]      tx_data_r;
    logic [7:0]      cur_ascii_r;
    logic            qualify_s;
    logic            push_s;
    logic            pop_s;
    logic [EW-1:0]   wr_entry_s;
    logic [EW-1:0]   head_s;
    logic [7:0]      head_hdr_s;

    // Event qualification, push/pop decisions and next FIFO level
    always_comb begin
        head_s = mem_r[rd_ptr_r];
`ifdef KEY_RELEASE_EN
        qualify_s  = key_valid && (key_ascii != 8'h00);
        wr_entry_s = {key_press, key_ascii};
        head_hdr_s = head_s[8] ? PRESS_HDR : RELEASE_HDR;
`else
        qualify_s  = key_valid && key_press && (key_ascii != 8'h00);
        wr_entry_s = key_ascii;
        head_hdr_s = PRESS_HDR;
`endif
        // A push is judged against the registered full flag, so a same-cycle pop cannot rescue it
        push_s = qualify_s && !full_r;
        pop_s  = (state_r == IDLE) && !empty_r;
        if (push_s && !pop_s) begin
            level_next_s = level_r + 1'b1;
        end else if (pop_s && !push_s) begin
            level_next_s = level_r - 1'b1;
        end else begin
            level_next_s = level_r;
        end
    end

    // Event FIFO storage, pointers, level flags and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= {LW{1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_entry_s;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            if (qualify_s && full_r) begin
                overflow_r <= 1'b1;
            end
            level_r <= level_next_s;
            full_r  <= (level_next_s == DEPTH_L);
            empty_r <= (level_next_s == {LW{1'b0}});
        end
    end

    // Frame sequencer; tx_start/tx_data are registered so the request appears in the SEND states
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            tx_start_r  <= 1'b0;
            tx_data_r   <= 8'h00;
            cur_ascii_r <= 8'h00;
        end else begin
            tx_start_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!empty_r) begin
                        cur_ascii_r <= head_s[7:0];
                        tx_data_r   <= head_hdr_s;
                        tx_start_r  <= 1'b1;
                        state_r     <= SEND_HDR;
                    end
                end
                SEND_HDR: state_r <= WAIT_HDR;
                WAIT_HDR: begin
                    if (tx_done) begin
                        tx_data_r  <= cur_ascii_r;
                        tx_start_r <= 1'b1;
                        state_r    <= SEND_DAT;
                    end
                end
                SEND_DAT: state_r <= WAIT_DAT;
                WAIT_DAT: begin
                    if (tx_done) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;
    assign level    = level_r;
    assign full     = full_r;
    assign empty    = empty_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_key_uart_framer.sv
// Randomized self-checking bench for key_uart_framer against a queue-based frame model.
module tb_key_uart_framer;

    localparam int DEPTH = 4;
`ifdef KEY_RELEASE_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic       key_press = 1'b0;
    logic [7:0] key_ascii = 8'h00;
    logic       tx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic       overflow;

    always #5 clk = ~clk;

    key_uart_framer #(.DEPTH(DEPTH), .PRESS_HDR(8'h01), .RELEASE_HDR(8'h02)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_press(key_press),
        .key_ascii(key_ascii), .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
        .level(level), .full(full), .empty(empty), .overflow(overflow)
    );

    // Model: pending events, frame progress, held output byte, and the UART's reply countdown
    logic [8:0] mq[$];
    logic [7:0] log_q[$];
    bit         m_idle = 1'b1;
    int         m_stage = 0;
    logic [7:0] m_cur = 8'h00;
    logic [7:0] m_data = 8'h00;
    bit         m_ovf = 1'b0;
    int         cnt = 0;
    bit         stall = 1'b0;
    bit         inject = 1'b0;
    int         cyc = 0;
    int         first_ts = -1;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs, predict the outcome of the edge, then compare
    task automatic tick(input bit kv, input bit kp, input logic [7:0] ka);
        bit         done;
        bit         exp_start;
        bit         full_pre;
        logic [8:0] e;
        key_valid = kv;
        key_press = kp;
        key_ascii = ka;
        done = 1'b0;
        if (!stall && cnt > 0) begin
            cnt--;
            done = (cnt == 0);
        end
        if (inject) done = 1'b1;
        tx_done = done;
        exp_start = 1'b0;
        if (rst) begin
            mq.delete();
            m_idle = 1'b1; m_stage = 0; m_ovf = 1'b0; m_data = 8'h00; cnt = 0;
        end else begin
            full_pre = (mq.size() == DEPTH);
            if (m_idle && mq.size() > 0) begin
                e = mq.pop_front();
                exp_start = 1'b1;
                m_data = (e[8] || !REL_EN) ? 8'h01 : 8'h02;
                m_cur = e[7:0];
                m_idle = 1'b0;
                m_stage = 1;
            end else if (done && m_stage == 1) begin
                exp_start = 1'b1;
                m_data = m_cur;
                m_stage = 2;
            end else if (done && m_stage == 2) begin
                m_stage = 0;
                m_idle = 1'b1;
            end
            if (kv && ka != 8'h00 && (kp || REL_EN)) begin
                if (full_pre) m_ovf = 1'b1;
                else mq.push_back({kp, ka});
            end
            if (exp_start) cnt = $urandom_range(2, 5);
        end
        @(posedge clk);
        #1;
        cyc++;
        check_eq("tx_start", tx_start, exp_start);
        check_eq("tx_data", tx_data, m_data);
        check_eq("level", level, mq.size());
        check_eq("full", full, mq.size() == DEPTH);
        check_eq("empty", empty, mq.size() == 0);
        check_eq("overflow", overflow, m_ovf);
        if (tx_start) begin
            log_q.push_back(tx_data);
            if (first_ts < 0) first_ts = cyc;
        end
        tx_done = 1'b0;
        key_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        for (int i = 0; i < 400 && !(m_idle && mq.size() == 0); i++) tick(1'b0, 1'b0, 8'h00);
        ok = m_idle && (mq.size() == 0);
        check_eq("drain_bound", ok, 1'b1);
        tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
    endtask

    initial begin
        int t_push;
        int starts;
        do_reset();

        // Single press 'A' from idle: header two cycles after the strobe cycle
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 8'h00);
        first_ts = -1;
        log_q.delete();
        t_push = cyc;
        tick(1'b1, 1'b1, 8'h41);
        tick(1'b0, 1'b0, 8'h00);
        check_eq("latency", first_ts - t_push, 2);
        drain();
        check_eq("a_len", log_q.size(), 2);
        check_eq("a_hdr", log_q[0], 8'h01);
        check_eq("a_dat", log_q[1], 8'h41);
        check_eq("a_empty", empty, 1'b1);

        // Unmapped key is ignored entirely
        log_q.delete();
        tick(1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 8'h00);
        check_eq("zero_log", log_q.size(), 0);
        check_eq("zero_ovf", overflow, 1'b0);

        // Press then release of 'x'
        log_q.delete();
        tick(1'b1, 1'b1, 8'h78);
        tick(1'b1, 1'b0, 8'h78);
        drain();
        check_eq("rel_len", log_q.size(), REL_EN ? 4 : 2);
        check_eq("rel_b0", log_q[0], 8'h01);
        check_eq("rel_b1", log_q[1], 8'h78);
        if (REL_EN) begin
            check_eq("rel_b2", log_q[2], 8'h02);
            check_eq("rel_b3", log_q[3], 8'h78);
        end

        // Overflow with the sequencer stalled waiting for the header to finish
        log_q.delete();
        tick(1'b1, 1'b1, 8'h61);
        for (int i = 0; i < 10 && m_stage != 1; i++) tick(1'b0, 1'b0, 8'h00);
        stall = 1'b1;
        for (int k = 1; k < 6; k++) tick(1'b1, 1'b1, 8'h61 + 8'(k));
        check_eq("ovf_level", level, 3'd4);
        check_eq("ovf_full", full, 1'b1);
        check_eq("ovf_flag", overflow, 1'b1);
        stall = 1'b0;
        drain();
        check_eq("ovf_len", log_q.size(), 10);
        for (int k = 0; k < 5; k++) check_eq("ovf_byte", log_q[2*k+1], 8'h61 + 8'(k));

        // Reset in WAIT_DAT with three events queued, then a stray tx_done
        do_reset();
        tick(1'b1, 1'b1, 8'h70);
        tick(1'b1, 1'b1, 8'h71);
        tick(1'b1, 1'b1, 8'h72);
        tick(1'b1, 1'b1, 8'h73);
        for (int i = 0; i < 20 && m_stage != 2; i++) tick(1'b0, 1'b0, 8'h00);
        stall = 1'b1;
        tick(1'b0, 1'b0, 8'h00);
        check_eq("pre_rst_level", level, 3'd3);
        rst = 1'b1;
        tick(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        stall = 1'b0;
        log_q.delete();
        for (int i = 0; i < 100; i++) begin
            inject = (i == 10);
            tick(1'b0, 1'b0, 8'h00);
        end
        inject = 1'b0;
        starts = log_q.size();
        check_eq("post_rst_starts", starts, 0);
        check_eq("post_rst_level", level, 3'd0);

        // Randomized traffic with occasional unmapped keys and releases
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 3)
                tick(1'b1, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
            else
                tick(1'b0, 1'b0, 8'h00);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
